// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit
//   Control side of the EX-stage 3-input operand forwarding mux. Tracks a
//   shadow pipeline of destination-register info (ex, mem, wb), compares the
//   ID-stage sources against it, registers the resulting mux selects so they
//   line up with the instruction when it reaches EX, and raises a
//   combinational stall on a load-use hazard.
//
//   Ports
//     clk, rst_n            clock, synchronous active-low reset
//     hold                  freeze every register (memory wait)
//     flush                 kill the ID instruction (bubble into EX)
//     id_valid              ID holds a real instruction
//     id_rs, id_rt          ID source registers
//     id_use_rs, id_use_rt  the source is actually read
//     id_rd                 ID destination register
//     id_regwrite           ID instruction writes the register file
//     id_memread            ID instruction is a load
//     stall                 hold PC and IF/ID, bubble into EX
//     fwd_a_sel, fwd_b_sel  0 = regfile, 1 = MEM/WB value, 2 = EX/MEM result
//     stall_count           saturating count of stall cycles
module fwd_hazard_unit #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hold,
  input  logic             flush,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_regwrite,
  input  logic             id_memread,
  output logic             stall,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic [CNT_W-1:0] stall_count
);

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             regwrite;
    logic             memread;
  } stage_t;

  localparam logic [1:0] SEL_RF  = 2'd0;
  localparam logic [1:0] SEL_MEM = 2'd1;
  localparam logic [1:0] SEL_EX  = 2'd2;

  stage_t ex_stg, mem_stg, wb_stg;
  stage_t id_stg;

  logic       use_a, use_b;
  logic       ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b;
  logic       load_hit;
  logic [1:0] a_sel_nxt, b_sel_nxt;

  // wb is visibility-only; folding it here keeps it referenced.
  logic unused_wb;
  assign unused_wb = ^wb_stg;

  function automatic logic writes(input stage_t s, input logic [REG_W-1:0] r);
    return s.valid & s.regwrite & (s.rd == r) & (r != '0);
  endfunction

  always_comb begin
    id_stg.valid    = id_valid;
    id_stg.rd       = id_rd;
    id_stg.regwrite = id_regwrite;
    id_stg.memread  = id_memread;

    use_a     = id_valid & id_use_rs;
    use_b     = id_valid & id_use_rt;
    ex_hit_a  = use_a & writes(ex_stg, id_rs);
    ex_hit_b  = use_b & writes(ex_stg, id_rt);
    mem_hit_a = use_a & writes(mem_stg, id_rs);
    mem_hit_b = use_b & writes(mem_stg, id_rt);

    // youngest producer wins
    a_sel_nxt = SEL_RF;
    if (ex_hit_a)       a_sel_nxt = SEL_EX;
    else if (mem_hit_a) a_sel_nxt = SEL_MEM;

    b_sel_nxt = SEL_RF;
    if (ex_hit_b)       b_sel_nxt = SEL_EX;
    else if (mem_hit_b) b_sel_nxt = SEL_MEM;

    // load result not available until MEM: one bubble, then forward from MEM/WB
    load_hit = ex_stg.valid & ex_stg.memread & (ex_hit_a | ex_hit_b);
    stall    = rst_n & id_valid & ~flush & load_hit;
  end

  // reset overrides hold; hold freezes everything else
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_stg      <= '0;
      mem_stg     <= '0;
      wb_stg      <= '0;
      fwd_a_sel   <= SEL_RF;
      fwd_b_sel   <= SEL_RF;
      stall_count <= '0;
    end else if (!hold) begin
      mem_stg <= ex_stg;
      wb_stg  <= mem_stg;
      if (flush || stall) begin
        ex_stg    <= '0;
        fwd_a_sel <= SEL_RF;
        fwd_b_sel <= SEL_RF;
      end else begin
        ex_stg    <= id_stg;
        fwd_a_sel <= a_sel_nxt;
        fwd_b_sel <= b_sel_nxt;
      end
      if (stall && (stall_count != '1))
        stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
module tb_fwd_hazard_unit;

  localparam int REG_W = 5;
  // narrow counter so saturation is reachable in a short run
  localparam int CNT_W = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             hold = 1'b0;
  logic             flush = 1'b0;
  logic             id_valid = 1'b0;
  logic [REG_W-1:0] id_rs = '0;
  logic [REG_W-1:0] id_rt = '0;
  logic             id_use_rs = 1'b0;
  logic             id_use_rt = 1'b0;
  logic [REG_W-1:0] id_rd = '0;
  logic             id_regwrite = 1'b0;
  logic             id_memread = 1'b0;
  logic             stall;
  logic [1:0]       fwd_a_sel;
  logic [1:0]       fwd_b_sel;
  logic [CNT_W-1:0] stall_count;

  fwd_hazard_unit #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .hold(hold), .flush(flush),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_memread(id_memread),
    .stall(stall), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // reference: list of in-flight producers, index 0 = youngest (in EX)
  typedef struct {
    bit v;
    int rd;
    bit rw;
    bit mr;
  } ent_t;

  ent_t pipe[3];
  int   m_a, m_b, m_cnt;

  function automatic bit produces(ent_t e, int r);
    return e.v && e.rw && (e.rd == r) && (r != 0);
  endfunction

  // scan from youngest to oldest; EX producer -> 2, MEM producer -> 1
  function automatic int pick(int r, bit used);
    if (!used) return 0;
    for (int i = 0; i < 2; i++)
      if (produces(pipe[i], r)) return 2 - i;
    return 0;
  endfunction

  function automatic bit m_stall();
    bit dep;
    if (!rst_n || !id_valid || flush) return 0;
    if (!(pipe[0].v && pipe[0].mr)) return 0;
    dep = (id_use_rs && produces(pipe[0], int'(id_rs))) ||
          (id_use_rt && produces(pipe[0], int'(id_rt)));
    return dep;
  endfunction

  task automatic model_clock();
    ent_t nw;
    int na, nb;
    bit st;
    st = m_stall();
    if (!rst_n) begin
      foreach (pipe[i]) pipe[i] = '{0, 0, 0, 0};
      m_a = 0; m_b = 0; m_cnt = 0;
    end else if (!hold) begin
      nw = '{0, 0, 0, 0};
      na = 0; nb = 0;
      if (!flush && !st) begin
        nw = '{id_valid, int'(id_rd), id_regwrite, id_memread};
        na = id_valid ? pick(int'(id_rs), id_use_rs) : 0;
        nb = id_valid ? pick(int'(id_rt), id_use_rt) : 0;
      end
      if (st && m_cnt < CNT_MAX) m_cnt++;
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = nw;
      m_a = na; m_b = nb;
    end
  endtask

  task automatic step();
    @(negedge clk);
    chk("stall", 32'(stall), 32'(m_stall()));
    chk("fwd_a_sel", 32'(fwd_a_sel), 32'(m_a));
    chk("fwd_b_sel", 32'(fwd_b_sel), 32'(m_b));
    chk("stall_count", 32'(stall_count), 32'(m_cnt));
    model_clock();
    @(posedge clk);
    #1;
  endtask

  task automatic instr(input bit v, input int rs, input bit urs, input int rt, input bit urt,
                       input int rd, input bit rw, input bit mr);
    id_valid = v;
    id_rs = REG_W'(rs); id_use_rs = urs;
    id_rt = REG_W'(rt); id_use_rt = urt;
    id_rd = REG_W'(rd); id_regwrite = rw; id_memread = mr;
  endtask

  task automatic nop();
    instr(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    foreach (pipe[i]) pipe[i] = '{0, 0, 0, 0};
    m_a = 0; m_b = 0; m_cnt = 0;
    @(posedge clk); #1;

    // reset
    rst_n = 0;
    step(); step();
    chk("rst_a", 32'(fwd_a_sel), 0);
    chk("rst_cnt", 32'(stall_count), 0);
    rst_n = 1;

    // ADD r3,r1,r2 ; SUB r4,r3,r5 back-to-back
    instr(1, 1, 1, 2, 1, 3, 1, 0); step();
    instr(1, 3, 1, 5, 1, 4, 1, 0); step();
    chk("ex_fwd_a", 32'(fwd_a_sel), 2);
    chk("ex_fwd_b", 32'(fwd_b_sel), 0);
    nop(); step(); step();

    // ADD r3 ; NOP ; SUB r4,r5,r3
    instr(1, 1, 1, 2, 1, 3, 1, 0); step();
    nop(); step();
    instr(1, 5, 1, 3, 1, 4, 1, 0); step();
    chk("mem_fwd_b", 32'(fwd_b_sel), 1);
    chk("mem_fwd_a", 32'(fwd_a_sel), 0);
    nop(); step(); step();

    // LW r2 ; ADD r6,r2,r2
    instr(1, 1, 1, 0, 0, 2, 1, 1); step();
    instr(1, 2, 1, 2, 1, 6, 1, 0); #1;
    chk("lu_stall", 32'(stall), 1);
    step();
    chk("lu_stall_clear", 32'(stall), 0);
    step();
    chk("lu_a", 32'(fwd_a_sel), 1);
    chk("lu_b", 32'(fwd_b_sel), 1);
    chk("lu_cnt", 32'(stall_count), 1);
    nop(); step(); step();

    // writes to r0, loads to r0, then reads of r0
    instr(1, 1, 1, 2, 1, 0, 1, 0); step();
    instr(1, 1, 1, 0, 0, 0, 1, 1); step();
    instr(1, 0, 1, 0, 1, 7, 1, 0); #1;
    chk("r0_stall", 32'(stall), 0);
    step();
    chk("r0_a", 32'(fwd_a_sel), 0);
    chk("r0_b", 32'(fwd_b_sel), 0);
    nop(); step(); step();

    // LW r2 ; dependent ADD killed by flush
    instr(1, 1, 1, 0, 0, 2, 1, 1); step();
    instr(1, 2, 1, 2, 1, 6, 1, 0); flush = 1; #1;
    chk("fl_stall", 32'(stall), 0);
    step();
    flush = 0; nop(); #1;
    chk("fl_a", 32'(fwd_a_sel), 0);
    chk("fl_cnt", 32'(stall_count), 1);
    step(); step();

    // hold for 3 cycles while a load-use is pending
    instr(1, 1, 1, 0, 0, 2, 1, 1); step();
    instr(1, 2, 1, 2, 1, 6, 1, 0); hold = 1;
    step(); step(); step();
    chk("hold_cnt", 32'(stall_count), 1);
    chk("hold_stall", 32'(stall), 1);
    hold = 0;
    step();
    chk("resume_cnt", 32'(stall_count), 2);
    step();
    chk("resume_a", 32'(fwd_a_sel), 1);
    nop(); step(); step();

    // randomized traffic with small register range to provoke hazards
    for (int i = 0; i < 3000; i++) begin
      instr($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 1) == 1,
            $urandom_range(0, 3), $urandom_range(0, 1) == 1, $urandom_range(0, 3),
            $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
      flush = ($urandom_range(0, 7) == 0);
      hold  = ($urandom_range(0, 7) == 0);
      rst_n = ($urandom_range(0, 63) != 0);
      if (!rst_n) hold = 0;
      step();
    end
    flush = 0; hold = 0; rst_n = 0;
    step();
    rst_n = 1;

    // saturate the stall counter: LW r2,0(r2) repeated stalls every other cycle
    instr(1, 2, 1, 0, 0, 2, 1, 1);
    for (int i = 0; i < 2 * (CNT_MAX + 6) + 2; i++) step();
    chk("sat_cnt", 32'(stall_count), 32'(CNT_MAX));

    rst_n = 0; nop();
    step();
    chk("final_rst_cnt", 32'(stall_count), 0);
    chk("final_rst_a", 32'(fwd_a_sel), 0);
    chk("final_rst_b", 32'(fwd_b_sel), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
